// File: rtl/megarom_flash_reader.sv
// MegaROM byte reader: fetches one byte per request from SPI flash (READ 03h, mode 0, clk/2)
// and keeps the last fetched byte in a single-entry cache so repeated reads skip the flash.
module megarom_flash_reader #(
   parameter logic [23:0] FLASH_BASE = 24'h100000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        megarom_rd_n,
   input  logic [21:0] megarom_address,
   output logic [7:0]  rdata,
   output logic        rdata_en,
   output logic        busy,
   output logic        flash_cs_n,
   output logic        flash_sck,
   output logic        flash_mosi,
   input  logic        flash_miso
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;

   state_t      state, state_d;
   logic [6:0]  cnt, cnt_d;
   logic [39:0] sh, sh_d;
   logic [7:0]  rx, rx_d;
   logic [21:0] addr_q, addr_q_d;
   logic        c_valid, c_valid_d;
   logic [21:0] c_tag, c_tag_d;
   logic [7:0]  c_data, c_data_d;
   logic        rd_prev, armed, armed_d, hit_pend, hit_pend_d;
   logic [7:0]  rdata_d;
   logic        rdata_en_d, busy_d, cs_n_d, sck_d, mosi_d;

   logic        req, accept, hit;
   logic [23:0] faddr;
   logic [39:0] frame;

   assign faddr = FLASH_BASE + {2'b00, megarom_address};
   assign frame = {8'h03, faddr, 8'h00};

   // armed blocks a rd_n that is already low when reset releases
   assign req    = armed && rd_prev && !megarom_rd_n;
   // the GAP cycle ends on the same edge that makes the block idle again
   assign accept = req && (state == IDLE || state == GAP);
   assign hit    = accept && c_valid && (c_tag == megarom_address);

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      sh_d       = sh;
      rx_d       = rx;
      addr_q_d   = addr_q;
      c_valid_d  = c_valid;
      c_tag_d    = c_tag;
      c_data_d   = c_data;
      armed_d    = armed | megarom_rd_n;
      hit_pend_d = 1'b0;
      rdata_d    = rdata;
      rdata_en_d = 1'b0;
      busy_d     = busy;
      cs_n_d     = flash_cs_n;
      sck_d      = flash_sck;
      mosi_d     = flash_mosi;

      if (hit_pend) begin
         rdata_d    = c_data;
         rdata_en_d = 1'b1;
      end

      case (state)
         IDLE: ;
         SHIFT: begin
            cnt_d = cnt + 7'd1;
            if (!cnt[0]) begin
               sck_d = 1'b1;
            end else begin
               // falling SCK edge: sample MISO and present the next MOSI bit
               sck_d  = 1'b0;
               mosi_d = sh[39];
               sh_d   = {sh[38:0], 1'b0};
               if (cnt >= 7'd65) rx_d = {rx[6:0], flash_miso};
            end
            if (cnt == 7'd79) begin
               state_d = DONE;
               cs_n_d  = 1'b1;
               mosi_d  = 1'b0;
               cnt_d   = 7'd0;
            end
         end
         DONE: begin
            rdata_d    = rx;
            rdata_en_d = 1'b1;
            c_valid_d  = 1'b1;
            c_tag_d    = addr_q;
            c_data_d   = rx;
            state_d    = GAP;
         end
         GAP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (accept) begin
         addr_q_d = megarom_address;
         if (hit) begin
            hit_pend_d = 1'b1;
         end else begin
            state_d = SHIFT;
            cnt_d   = 7'd0;
            cs_n_d  = 1'b0;
            sck_d   = 1'b0;
            mosi_d  = frame[39];
            sh_d    = {frame[38:0], 1'b0};
            rx_d    = 8'h00;
            busy_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 7'd0;
         sh         <= 40'd0;
         rx         <= 8'h00;
         addr_q     <= 22'd0;
         c_valid    <= 1'b0;
         c_tag      <= 22'd0;
         c_data     <= 8'h00;
         rd_prev    <= 1'b1;
         armed      <= 1'b0;
         hit_pend   <= 1'b0;
         rdata      <= 8'h00;
         rdata_en   <= 1'b0;
         busy       <= 1'b0;
         flash_cs_n <= 1'b1;
         flash_sck  <= 1'b0;
         flash_mosi <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         sh         <= sh_d;
         rx         <= rx_d;
         addr_q     <= addr_q_d;
         c_valid    <= c_valid_d;
         c_tag      <= c_tag_d;
         c_data     <= c_data_d;
         rd_prev    <= megarom_rd_n;
         armed      <= armed_d;
         hit_pend   <= hit_pend_d;
         rdata      <= rdata_d;
         rdata_en   <= rdata_en_d;
         busy       <= busy_d;
         flash_cs_n <= cs_n_d;
         flash_sck  <= sck_d;
         flash_mosi <= mosi_d;
      end
   end

endmodule

// File: doc/megarom_flash_reader.md
MEGAROM_FLASH_READER -- requirements
Module: megarom_flash_reader

Interface
REQ-001 Parameter FLASH_BASE, default 24'h100000, byte offset of MegaROM image in SPI flash.
REQ-002 clk  input  1  system clock (42.955 MHz); all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 megarom_rd_n  input  1  active-low read request from megarom mapper.
REQ-005 megarom_address  input  22  MegaROM byte address, valid while megarom_rd_n low.
REQ-006 rdata  output  8  read data, valid when rdata_en high.
REQ-007 rdata_en  output  1  one-cycle read-data-valid pulse.
REQ-008 busy  output  1  high while a flash transaction is in progress.
REQ-009 flash_cs_n  output  1  SPI flash chip select, active low.
REQ-010 flash_sck  output  1  SPI clock, mode 0, clk/2.
REQ-011 flash_mosi  output  1  SPI data to flash.
REQ-012 flash_miso  input  1  SPI data from flash.

Function
REQ-013 Request = megarom_rd_n sampled 0 at edge N with registered previous sample 1 (falling edge); megarom_address latched at edge N.
REQ-014 States: IDLE, SHIFT, DONE, GAP; only IDLE accepts requests.
REQ-015 Requests detected in any state other than IDLE are dropped; no queuing.
REQ-016 Cache: one entry {valid, tag[21:0], data[7:0]}; a request in IDLE with valid=1 and tag=latched address is a hit.
REQ-017 Hit: no flash activity; rdata=cached data, rdata_en=1 at edge N+1 only; state stays IDLE; busy stays 0.
REQ-018 Miss: IDLE->SHIFT at edge N; flash_cs_n=0, busy=1, flash_sck=0, flash_mosi=frame bit 39 from edge N.
REQ-019 Frame = 40 bits MSB first: 8'h03, 24-bit flash address, 8 dummy zeros; flash address = (FLASH_BASE + {2'b00, megarom_address}) modulo 2^24.
REQ-020 SHIFT: 80 cycles, 2 per bit; phase 0 flash_sck=0 with flash_mosi stable; phase 1 flash_sck=1.
REQ-021 flash_mosi changes only on the edge that drives flash_sck 1->0, or on SHIFT entry.
REQ-022 During bits 32..39, flash_miso sampled at the edge ending phase 1, shifted MSB first into rdata shift register.
REQ-023 After 80th SHIFT cycle (edge N+80): state DONE, flash_cs_n=1, flash_sck=0.
REQ-024 DONE (edge N+81): rdata=assembled byte, rdata_en=1 for that cycle only; cache valid=1, tag=latched address, data=byte.
REQ-025 GAP: one cycle, flash_cs_n held 1; busy=0 and state IDLE from edge N+82; earliest next request detectable at edge N+82.
REQ-026 Miss latency: rdata_en high exactly 81 cycles after detecting edge N; hit latency 1 cycle.
REQ-027 rdata holds its last value between pulses; rdata_en never high for two consecutive cycles.
REQ-028 megarom_address changes after edge N have no effect on the transaction in progress.
REQ-029 flash_sck idles 0 and flash_mosi idles 0 whenever flash_cs_n=1.

Reset
REQ-030 reset_n low: immediately state=IDLE, flash_cs_n=1, flash_sck=0, flash_mosi=0, rdata=8'h00, rdata_en=0, busy=0, cache valid=0, previous megarom_rd_n sample=1.
REQ-031 Reset mid-SHIFT aborts the transaction: flash_cs_n goes 1 asynchronously, no rdata_en pulse, cache not updated.
REQ-032 First request after reset release is always a miss; a megarom_rd_n already low at release is not a request until it returns high and falls again.

Verification
REQ-033 Miss: address 22'h000123, flash model returns 8'hA5 -> MOSI frame 03h,10h,01h,23h,00h; rdata=8'hA5, rdata_en pulse at N+81; flash_cs_n low N..N+79 inclusive.
REQ-034 Hit: repeat 22'h000123 after completion -> rdata_en at N+1 with 8'hA5, flash_cs_n stays 1, busy stays 0.
REQ-035 Wrap: FLASH_BASE=24'hF00000, address 22'h3FFFFF -> flash address 24'h2FFFFF on MOSI.
REQ-036 Drop: second rd_n falling edge at N+40 with address 22'h000200 -> ignored, exactly one rdata_en pulse, cache tag stays first address.
REQ-037 Abort: reset_n low at N+30 -> flash_cs_n=1 at once; after release, re-read of same address performs full flash transaction (miss).
REQ-038 Back-to-back: new request at N+82 with different address -> accepted as miss, second pulse at N+163.
